// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if
// Bundles the run-control handshake between the top-level ports, the
// instruction decoder and the exec_sequencer.
//   req, opcode            : toward the sequencer (start request, decoded opcode)
//   core_rst, run_en,
//   pc_hold, done, busy,
//   cycle_count, timeout   : from the sequencer (core control and run status)
// Modports: master = surrounding logic / bench, slave = exec_sequencer.
interface exec_sequencer_if #(
  parameter int CW = 16
);
  logic          req;
  logic [4:0]    opcode;
  logic          core_rst;
  logic          run_en;
  logic          pc_hold;
  logic          done;
  logic          busy;
  logic [CW-1:0] cycle_count;
  logic          timeout;

  modport master (
    output req, opcode,
    input  core_rst, run_en, pc_hold, done, busy, cycle_count, timeout
  );

  modport slave (
    input  req, opcode,
    output core_rst, run_en, pc_hold, done, busy, cycle_count, timeout
  );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer
// Run-level controller for the 9-bit-instruction core. Holds the core in
// reset while idle, resets and launches it on a rising edge of req, gates
// architectural writes every cycle, inserts one stall cycle per data-memory
// load and ends the run on the halt opcode.
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous, active-low
//   bus    : exec_sequencer_if.slave (req, opcode in; core_rst, run_en,
//            pc_hold, done, busy, cycle_count, timeout out)
// Optional feature: define EXEC_WATCHDOG_EN to end a run after MAX_CYCLES
// run cycles and flag it on timeout. Without it, timeout is tied to 0.
module exec_sequencer #(
  parameter int             D           = 12,
  parameter int             CW          = 16,
  parameter logic [4:0]     HALT_OP     = 5'b11111,
  parameter logic [4:0]     LOAD_OP     = 5'b01000,
  parameter int             INIT_CYCLES = 2,
  parameter logic [15:0]    MAX_CYCLES  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  exec_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_LDWAIT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Elaboration-time guard on the parameter ranges.
  if (INIT_CYCLES < 1 || INIT_CYCLES > 15 || D < 1 || MAX_CYCLES == 16'd0) begin : g_bad_cfg
    $error("exec_sequencer: illegal parameter value");
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic          req_q;
  logic [3:0]    init_cnt;
  logic [CW-1:0] cyc_cnt;
  logic          timeout_q;
  logic          start;
  logic          in_run;
  logic          wd_fire;

  assign start  = bus.req & ~req_q;
  assign in_run = (state == S_RUN) || (state == S_LDWAIT);

`ifdef EXEC_WATCHDOG_EN
  assign wd_fire = in_run && (cyc_cnt == CW'(MAX_CYCLES - 16'd1));
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_INIT;
      S_INIT:   if (init_cnt == 4'(INIT_CYCLES - 1)) state_nxt = S_RUN;
      S_RUN: begin
        if (wd_fire)                    state_nxt = S_DONE;
        else if (bus.opcode == HALT_OP) state_nxt = S_DONE;
        else if (bus.opcode == LOAD_OP) state_nxt = S_LDWAIT;
      end
      S_LDWAIT: state_nxt = wd_fire ? S_DONE : S_RUN;
      S_DONE:   if (start) state_nxt = S_INIT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State, start-edge and counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      req_q     <= 1'b0;
      init_cnt  <= '0;
      cyc_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // The edge detector always tracks req, so an edge seen while busy is consumed.
      req_q <= bus.req;
      if (state_nxt == S_INIT && state != S_INIT) begin
        init_cnt  <= '0;
        cyc_cnt   <= '0;
        timeout_q <= 1'b0;
      end else begin
        if (state == S_INIT) init_cnt <= init_cnt + 4'd1;
        if (in_run)          cyc_cnt  <= sat_inc(cyc_cnt);
        if (wd_fire)         timeout_q <= 1'b1;
      end
    end
  end

  // Output decode from state and opcode
  always_comb begin
    bus.core_rst = 1'b0;
    bus.run_en   = 1'b0;
    bus.pc_hold  = 1'b0;
    bus.done     = 1'b0;
    bus.busy     = 1'b0;
    case (state)
      S_IDLE: bus.core_rst = 1'b1;
      S_INIT: begin
        bus.core_rst = 1'b1;
        bus.busy     = 1'b1;
      end
      S_RUN: begin
        bus.busy = 1'b1;
        // Halt and load both stall the PC; a halt is never executed.
        if (wd_fire || bus.opcode == HALT_OP || bus.opcode == LOAD_OP) begin
          bus.pc_hold = 1'b1;
        end else begin
          bus.run_en = 1'b1;
        end
      end
      S_LDWAIT: begin
        bus.busy = 1'b1;
        // A watchdog expiry abandons the pending load instead of committing it.
        if (wd_fire) bus.pc_hold = 1'b1;
        else         bus.run_en  = 1'b1;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        bus.pc_hold = 1'b1;
      end
      default: bus.core_rst = 1'b1;
    endcase
    // A reset arriving mid-run must not let the current cycle commit.
    if (!reset) bus.run_en = 1'b0;
  end

  assign bus.cycle_count = cyc_cnt;
  assign bus.timeout     = timeout_q;

endmodule
